// File: rtl/time_set_if.sv
// time_set_if: push-button pulses and 1 Hz tick in, time/mode/display fields out
interface time_set_if;
    logic       tick_1hz;
    logic       short_pression;
    logic       long_pression;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [1:0] mode;
    logic [2:0] edit_field;
    logic       day_pulse;
    modport slave (
        input  tick_1hz, short_pression, long_pression,
        output hour, minute, second, mode, edit_field, day_pulse
    );
    modport master (
        output tick_1hz, short_pression, long_pression,
        input  hour, minute, second, mode, edit_field, day_pulse
    );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: time-of-day counter with single-button hour/minute/second setting and idle timeout
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic        sysclk,
    input  logic        rst_n,
    time_set_if.slave   bus
);
    localparam int unsigned IW = $clog2(TIMEOUT_S + 1);
    typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} mode_e;
    mode_e   mode_q, mode_d;
    logic [4:0] hour_q, hour_d;
    logic [5:0] minute_q, minute_d;
    logic [5:0] second_q, second_d;
    logic [IW-1:0] idle_q, idle_d;
    logic day_q, day_d;
    logic short_w, sec_w, min_w, hr_w;
    // long press overrides a simultaneous short press
    assign short_w = bus.short_pression & ~bus.long_pression;
    assign sec_w   = second_q == 6'd59;
    assign min_w   = minute_q == 6'd59;
    assign hr_w    = hour_q == 5'd23;
    always_comb begin
        mode_d   = mode_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;
        idle_d   = idle_q;
        day_d    = 1'b0;
        if (mode_q == RUN) begin
            idle_d = '0;
            if (bus.tick_1hz) begin
                second_d = sec_w ? 6'd0 : second_q + 6'd1;
                minute_d = sec_w ? (min_w ? 6'd0 : minute_q + 6'd1) : minute_q;
                hour_d   = (sec_w && min_w) ? (hr_w ? 5'd0 : hour_q + 5'd1) : hour_q;
                day_d    = sec_w && min_w && hr_w;
            end
            if (bus.long_pression) mode_d = SET_HOUR;
        end else if (bus.long_pression) begin
            mode_d = (mode_q == SET_SEC) ? RUN : mode_e'(mode_q + 2'd1);
            idle_d = '0;
        end else if (short_w) begin
            idle_d   = '0;
            hour_d   = (mode_q == SET_HOUR) ? (hr_w ? 5'd0 : hour_q + 5'd1) : hour_q;
            minute_d = (mode_q == SET_MIN) ? (min_w ? 6'd0 : minute_q + 6'd1) : minute_q;
            second_d = (mode_q == SET_SEC) ? 6'd0 : second_q;
        end else if (bus.tick_1hz) begin
            // reaching TIMEOUT_S idle ticks drops back to RUN, fields kept
            mode_d = (idle_q == IW'(TIMEOUT_S - 1)) ? RUN : mode_q;
            idle_d = (idle_q == IW'(TIMEOUT_S - 1)) ? '0 : idle_q + 1'b1;
        end
    end
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= RUN;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
            idle_q   <= '0;
            day_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            idle_q   <= idle_d;
            day_q    <= day_d;
        end
    end
    assign bus.hour       = hour_q;
    assign bus.minute     = minute_q;
    assign bus.second     = second_q;
    assign bus.mode       = mode_q;
    assign bus.edit_field = (mode_q == SET_HOUR) ? 3'b100 :
                            (mode_q == SET_MIN)  ? 3'b010 :
                            (mode_q == SET_SEC)  ? 3'b001 : 3'b000;
    assign bus.day_pulse  = day_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and random stimulus against a seconds-of-day reference model
module tb_time_set_ctrl;
    localparam int TO = 10;
    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    int n_chk  = 0;
    int n_fail = 0;
    int m_secs = 0;
    int m_mode = 0;
    int m_idle = 0;
    int m_day  = 0;
    time_set_if bus();
    time_set_ctrl #(.TIMEOUT_S(TO)) dut (
        .sysclk(sysclk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    always #5 sysclk = ~sysclk;
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    // model: time as seconds of day, mode as 0..3, idle as plain tick count
    task automatic model_step(input bit t, input bit s, input bit l);
        int h, m, sc;
        m_day = 0;
        if (m_mode == 0) begin
            if (t) begin
                m_secs = (m_secs + 1) % 86400;
                m_day  = (m_secs == 0);
            end
            if (l) m_mode = 1;
            m_idle = 0;
        end else if (l) begin
            m_mode = (m_mode + 1) % 4;
            m_idle = 0;
        end else if (s) begin
            h  = m_secs / 3600;
            m  = (m_secs / 60) % 60;
            sc = m_secs % 60;
            if (m_mode == 1) h = (h + 1) % 24;
            if (m_mode == 2) m = (m + 1) % 60;
            if (m_mode == 3) sc = 0;
            m_secs = h * 3600 + m * 60 + sc;
            m_idle = 0;
        end else if (t) begin
            m_idle++;
            if (m_idle == TO) begin
                m_mode = 0;
                m_idle = 0;
            end
        end
    endtask
    task automatic model_reset();
        m_secs = 0; m_mode = 0; m_idle = 0; m_day = 0;
    endtask
    task automatic cyc(input bit t, input bit s, input bit l);
        @(negedge sysclk);
        bus.tick_1hz = t; bus.short_pression = s; bus.long_pression = l;
        model_step(t, s, l);
        @(posedge sysclk);
        #1;
        bus.tick_1hz = 1'b0; bus.short_pression = 1'b0; bus.long_pression = 1'b0;
    endtask
    task automatic do_reset();
        @(negedge sysclk);
        rst_n = 1'b0;
        model_reset();
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask
    always @(posedge sysclk) begin
        #2;
        chk("hour", int'(bus.hour), m_secs / 3600);
        chk("minute", int'(bus.minute), (m_secs / 60) % 60);
        chk("second", int'(bus.second), m_secs % 60);
        chk("mode", int'(bus.mode), m_mode);
        chk("edit_field", int'(bus.edit_field), m_mode == 0 ? 0 : (4 >> (m_mode - 1)));
        chk("day_pulse", int'(bus.day_pulse), m_day);
    end
    initial begin
        bus.tick_1hz = 1'b0; bus.short_pression = 1'b0; bus.long_pression = 1'b0;
        #12;
        chk("reset_mode", int'(bus.mode), 0);
        chk("reset_hour", int'(bus.hour), 0);
        chk("reset_edit", int'(bus.edit_field), 0);
        do_reset();
        cyc(0, 0, 1); chk("cyc_mode1", int'(bus.mode), 1); chk("cyc_edit1", int'(bus.edit_field), 4);
        cyc(0, 0, 1); chk("cyc_mode2", int'(bus.mode), 2); chk("cyc_edit2", int'(bus.edit_field), 2);
        cyc(0, 0, 1); chk("cyc_mode3", int'(bus.mode), 3); chk("cyc_edit3", int'(bus.edit_field), 1);
        cyc(0, 0, 1); chk("cyc_mode0", int'(bus.mode), 0); chk("cyc_edit0", int'(bus.edit_field), 0);
        cyc(0, 0, 1);
        repeat (24) cyc(0, 1, 0);
        chk("hour_wrap", int'(bus.hour), 0);
        cyc(0, 0, 1);
        repeat (61) cyc(0, 1, 0);
        chk("min_wrap", int'(bus.minute), 1);
        repeat (9) cyc(1, 0, 0);
        chk("frozen_min", int'(bus.minute), 1);
        chk("frozen_sec", int'(bus.second), 0);
        chk("frozen_mode", int'(bus.mode), 2);
        cyc(0, 0, 1); cyc(0, 0, 1);
        do_reset();
        cyc(0, 0, 1);
        repeat (23) cyc(0, 1, 0);
        cyc(0, 0, 1);
        repeat (59) cyc(0, 1, 0);
        cyc(0, 0, 1); cyc(0, 1, 0); cyc(0, 0, 1);
        chk("set_run", int'(bus.mode), 0);
        repeat (59) cyc(1, 0, 0);
        chk("pre_roll_s", int'(bus.second), 59);
        chk("pre_roll_h", int'(bus.hour), 23);
        cyc(1, 0, 0);
        chk("roll_h", int'(bus.hour), 0);
        chk("roll_m", int'(bus.minute), 0);
        chk("roll_s", int'(bus.second), 0);
        chk("roll_day", int'(bus.day_pulse), 1);
        cyc(0, 0, 0);
        chk("day_one_cycle", int'(bus.day_pulse), 0);
        cyc(0, 0, 1);
        repeat (8) cyc(1, 0, 0);
        cyc(1, 1, 0);
        chk("to_hour", int'(bus.hour), 1);
        repeat (9) cyc(1, 0, 0);
        chk("to_still_set", int'(bus.mode), 1);
        cyc(1, 0, 0);
        chk("to_expired", int'(bus.mode), 0);
        chk("to_hour_kept", int'(bus.hour), 1);
        do_reset();
        cyc(0, 0, 1);
        repeat (5) cyc(0, 1, 0);
        cyc(0, 1, 1);
        chk("sim_mode", int'(bus.mode), 2);
        chk("sim_hour", int'(bus.hour), 5);
        cyc(1, 1, 0);
        chk("sim_min", int'(bus.minute), 1);
        repeat (9) cyc(1, 0, 0);
        chk("sim_idle_clr", int'(bus.mode), 2);
        cyc(1, 0, 0);
        chk("sim_idle_to", int'(bus.mode), 0);
        cyc(1, 0, 1);
        chk("run_long_tick_s", int'(bus.second), 1);
        chk("run_long_tick_m", int'(bus.mode), 1);
        cyc(0, 0, 1); cyc(0, 0, 1);
        cyc(1, 0, 1);
        chk("sec_long_tick_m", int'(bus.mode), 0);
        chk("sec_long_tick_s", int'(bus.second), 1);
        do_reset();
        cyc(0, 0, 1);
        repeat (12) cyc(0, 1, 0);
        cyc(0, 0, 1);
        repeat (34) cyc(0, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_hour", int'(bus.hour), 0);
        chk("async_min", int'(bus.minute), 0);
        chk("async_mode", int'(bus.mode), 0);
        model_reset();
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(19) == 0);
        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(1) == 0, $urandom_range(30) == 0, $urandom_range(60) == 0);
        cyc(0, 0, 0);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
